// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown timer: FSM state encoding and default widths.
// Optional feature macro used by the top level: COUNTDOWN_AUTO_RELOAD_EN.
package countdown_pkg;

  localparam int DEF_WIDTH          = 8;
  localparam int DEF_PRESCALE_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

endpackage

// File: rtl/countdown_timer_tick_gen.sv
// Prescaler for the countdown timer: emits one tick every div+1 enabled cycles.
// The compare is >= so lowering div below the running prescaler fires a tick
// right away instead of letting the counter wrap around.
module tick_gen
  import countdown_pkg::*;
#(
  parameter int PRESCALE_WIDTH = DEF_PRESCALE_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      en,
  input  logic [PRESCALE_WIDTH-1:0] div,
  output logic                      tick
);

  logic [PRESCALE_WIDTH-1:0] preQ_q;
  logic [PRESCALE_WIDTH-1:0] preQ_d;
  logic                      reached;

  assign reached = (preQ_q >= div);
  assign tick    = en && reached;

  // Next prescaler value: clear wins, otherwise count while enabled and restart on a tick
  always_comb begin
    preQ_d = preQ_q;
    if (clr) begin
      preQ_d = '0;
    end else if (en) begin
      if (reached) begin
        preQ_d = '0;
      end else begin
        preQ_d = preQ_q + PRESCALE_WIDTH'(1);
      end
    end
  end

  // Prescaler register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      preQ_q <= '0;
    end else begin
      preQ_q <= preQ_d;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Loadable countdown timer with programmable tick prescaler and expiry flag.
// Optional feature macro: COUNTDOWN_AUTO_RELOAD_EN adds an auto_reload input
// that restarts the count from the last loaded value instead of expiring.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int PRESCALE_WIDTH = DEF_PRESCALE_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ld,
  input  logic [WIDTH-1:0]          v,
  input  logic                      en,
  input  logic [PRESCALE_WIDTH-1:0] div,
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  input  logic                      auto_reload,
`endif
  output logic [WIDTH-1:0]          count,
  output logic                      busy,
  output logic                      expired,
  output logic                      done
);

  state_t            state_q;
  logic [WIDTH-1:0]  count_q;
  logic              busy_q;
  logic              expired_q;
  logic              done_q;
  logic              tick;
  logic              tickEn;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [WIDTH-1:0]  reload_q;
`endif

  // The prescaler only advances while actually running; a load restarts it
  assign tickEn = (state_q == RUN) && en;

  tick_gen #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) uTickGen (
    .clk  (clk),
    .rst  (rst),
    .clr  (ld),
    .en   (tickEn),
    .div  (div),
    .tick (tick)
  );

  // FSM, count register and registered status outputs; a load overrides any tick
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      busy_q    <= 1'b0;
      expired_q <= 1'b0;
      done_q    <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_q  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      if (ld) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        reload_q <= v;
`endif
        expired_q <= 1'b0;
        if (v != '0) begin
          count_q <= v;
          busy_q  <= 1'b1;
          state_q <= en ? RUN : PAUSE;
        end else begin
          count_q <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      end else begin
        case (state_q)
          RUN: begin
            if (!en) begin
              state_q <= PAUSE;
            end else if (tick) begin
              if (count_q > WIDTH'(1)) begin
                count_q <= count_q - WIDTH'(1);
              end else if (count_q == WIDTH'(1)) begin
                done_q <= 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                if (auto_reload) begin
                  count_q <= reload_q;
                end else begin
                  count_q   <= '0;
                  busy_q    <= 1'b0;
                  expired_q <= 1'b1;
                  state_q   <= EXPIRED;
                end
`else
                count_q   <= '0;
                busy_q    <= 1'b0;
                expired_q <= 1'b1;
                state_q   <= EXPIRED;
`endif
              end
            end
          end
          PAUSE: begin
            if (en) begin
              state_q <= RUN;
            end
          end
          IDLE, EXPIRED: begin
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign count   = count_q;
  assign busy    = busy_q;
  assign expired = expired_q;
  assign done    = done_q;

endmodule
